// File: rtl/bcd_encoder.sv
// -----------------------------------------------------------------------------
// bcd_encoder
//
// Converts a signed four-digit BCD number (-9999..+9999) into a 16-bit
// two's-complement value. The digits are folded into a 14-bit binary
// accumulator one per clock (thousands first, acc = acc*10 + digit), and the
// sign is applied in a final cycle that also registers the result.
// Start-to-result latency is 5 clocks. A new conversion can start on the clock
// after the result, so the block delivers at most one result every 6 clocks.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  conversion request, only honoured while idle
//   num_C3..0  in   4  BCD digits, thousands..units
//   sign       in   1  1 = negative, 0 = positive
//   data_outH  out  8  result bits [15:8]
//   data_outL  out  8  result bits [7:0]
//   busy       out  1  conversion in progress
//   done       out  1  one-cycle pulse when the result registers update
//   err        out  1  last accepted conversion contained a digit above 9
// -----------------------------------------------------------------------------
module bcd_encoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] num_C3,
    input  logic [3:0] num_C2,
    input  logic [3:0] num_C1,
    input  logic [3:0] num_C0,
    input  logic       sign,
    output logic [7:0] data_outH,
    output logic [7:0] data_outL,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, ACC, FIN} state_t;

    state_t              state;
    logic [15:0]         digits_q;   // captured {C3, C2, C1, C0}
    logic                sign_q;
    logic [13:0]         acc;
    logic [1:0]          idx;        // digit being folded in, 3 down to 0
    logic [3:0]          cur_digit;
    logic signed [15:0]  result_c;
    logic                digits_ok;

    // acc*10 + d built from two shifts; 9999 fits in 14 bits, so valid input
    // never wraps. Invalid digits may wrap, but that result is discarded.
    function automatic logic [13:0] mac10(input logic [13:0] a, input logic [3:0] d);
        return (a << 3) + (a << 1) + {10'd0, d};
    endfunction

    // Apply the sign; a zero magnitude stays zero so there is no negative zero.
    function automatic logic signed [15:0] to_twos(input logic [13:0] mag, input logic neg);
        logic signed [15:0] ext;
        ext = signed'({2'b00, mag});
        return (neg && (mag != 14'd0)) ? -ext : ext;
    endfunction

    function automatic logic bcd_valid(input logic [15:0] d);
        return (d[15:12] <= 4'd9) && (d[11:8] <= 4'd9) &&
               (d[7:4]   <= 4'd9) && (d[3:0]  <= 4'd9);
    endfunction

    assign cur_digit = digits_q[{idx, 2'b00} +: 4];
    assign result_c  = to_twos(acc, sign_q);
    assign digits_ok = bcd_valid(digits_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            digits_q  <= 16'd0;
            sign_q    <= 1'b0;
            acc       <= 14'd0;
            idx       <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            data_outH <= 8'h00;
            data_outL <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        digits_q <= {num_C3, num_C2, num_C1, num_C0};
                        sign_q   <= sign;
                        acc      <= 14'd0;
                        idx      <= 2'd3;
                        busy     <= 1'b1;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    acc <= mac10(acc, cur_digit);
                    if (idx == 2'd0) begin
                        state <= FIN;
                    end else begin
                        idx <= idx - 2'd1;
                    end
                end
                FIN: begin
                    if (digits_ok) begin
                        {data_outH, data_outL} <= result_c;
                        err                    <= 1'b0;
                    end else begin
                        data_outH <= 8'h00;
                        data_outL <= 8'h00;
                        err       <= 1'b1;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_encoder.sv
module tb_bcd_encoder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] num_C3, num_C2, num_C1, num_C0;
    logic       sign;
    logic [7:0] data_outH, data_outL;
    logic       busy, done, err;

    typedef struct {
        logic [15:0] val;
        logic        e;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    bcd_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_C3    (num_C3),
        .num_C2    (num_C2),
        .num_C1    (num_C1),
        .num_C0    (num_C0),
        .sign      (sign),
        .data_outH (data_outH),
        .data_outL (data_outL),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation,
    // including the edge on which it was predicted to appear.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {16'd0, data_outH, data_outL}, {16'd0, e.val});
                check("err", {31'd0, err}, {31'd0, e.e});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge; start is sampled on the next edge (k).
    task automatic issue(input logic [3:0] d3, d2, d1, d0, input logic s,
                         input logic push, input logic [15:0] val, input logic e);
        exp_t x;
        num_C3 = d3; num_C2 = d2; num_C1 = d1; num_C0 = d0; sign = s;
        start  = 1'b1;
        if (push) begin
            x.val = val; x.e = e; x.cyc = cyc + 1 + 5;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run(input logic [3:0] d3, d2, d1, d0, input logic s,
                       input logic [15:0] val, input logic e);
        issue(d3, d2, d1, d0, s, 1'b1, val, e);
        wait_edges(5);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; start = 1'b0; sign = 1'b0;
        num_C3 = 4'd0; num_C2 = 4'd0; num_C1 = 4'd0; num_C0 = 4'd0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err",  {31'd0, err},  32'd0);
        check("rst_out",  {16'd0, data_outH, data_outL}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1234 positive with busy profile across the conversion
        issue(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1, 16'h04D2, 1'b0);
        check("busy_k", {31'd0, busy}, 32'd1);
        wait_edges(4);
        check("busy_k4", {31'd0, busy}, 32'd1);
        wait_edges(1);
        check("busy_k5", {31'd0, busy}, 32'd0);

        run(4'd9, 4'd9, 4'd9, 4'd9, 1'b1, 16'hD8F1, 1'b0);
        run(4'd0, 4'd0, 4'd0, 4'd1, 1'b1, 16'hFFFF, 1'b0);
        run(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 16'h0000, 1'b0);
        run(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 16'h270F, 1'b0);
        run(4'd5, 4'd0, 4'd0, 4'd0, 1'b1, 16'hEC78, 1'b0);
        run(4'd1, 4'hA, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b1);
        run(4'd0, 4'd0, 4'd4, 4'd2, 1'b0, 16'h002A, 1'b0);
        run(4'd0, 4'd0, 4'd0, 4'hF, 1'b1, 16'h0000, 1'b1);

        // Re-pulse at k+2 ignored; inputs scrambled mid-conversion; start at k+6 accepted
        issue(4'd0, 4'd3, 4'd2, 4'd1, 1'b0, 1'b1, 16'h0141, 1'b0);
        wait_edges(1);
        issue(4'd8, 4'd8, 4'd8, 4'd8, 1'b1, 1'b0, 16'h0000, 1'b0);
        num_C3 = 4'd7; num_C2 = 4'd7; sign = 1'b1;
        wait_edges(3);
        issue(4'd0, 4'd0, 4'd1, 4'd0, 1'b1, 1'b1, 16'hFFF6, 1'b0);
        wait_edges(5);
        check("hold_out", {16'd0, data_outH, data_outL}, 32'h0000FFF6);

        // Asynchronous reset mid-conversion: no result expected
        issue(4'd7, 4'd7, 4'd7, 4'd7, 1'b0, 1'b0, 16'h0000, 1'b0);
        wait_edges(2);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_out",  {16'd0, data_outH, data_outL}, 32'd0);
        check("arst_err",  {31'd0, err}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        wait_edges(6);
        rst_n = 1'b1;
        wait_edges(1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        run(4'd0, 4'd1, 4'd0, 4'd0, 1'b0, 16'h0064, 1'b0);

        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        check("pending_results", sb.size(), 32'd0);
        wait_edges(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
